md_unit: RTL and testbench
==========================

# md_unit

- Multiply/divide unit of the P6 pipelined MIPS core; sits in the E stage beside the ALU.
- Executes mult, multu, div, divu and msub over several cycles, and holds the architectural HI/LO registers for mthi, mtlo, mfhi and mflo.
- Consumes `start` and the 4-bit `alupro_op` code produced by the decode controller.
- Returns `busy` so the hazard unit can stall later HI/LO users.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu/msub
- DIV_CYCLES, 10, busy duration for div/divu

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  launch a multi-cycle op (valid with op 1,2,3,4,9)
- alupro_op  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 mflo, 8 mfhi, 9 msub; 10–15 reserved
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- busy  output  1  operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- md_out  output  32  combinational read: HI when op=8, LO when op=7, else 0

## Operation
- State:
  - HI, LO, 32 bits each
  - `cnt`, 4 bits; `busy = (cnt != 0)`
  - `res_hi`, `res_lo`, 32 bits each (pending result)
  - `pend_valid`, 1 bit
- Accepted launch: `start=1`, `busy=0`, op in {1,2,3,4,9}.
  - At that edge, the result is computed from the sampled A/B (and current HI/LO for msub) into `res_hi`/`res_lo`.
  - `cnt` is loaded with the op latency.
- Ignored inputs:
  - `start` with busy=1, or with any other op, has no effect.
  - op 10–15 is a no-op.
- Arithmetic:
  - mult: {HI,LO} = signed(A)·signed(B), full 64-bit product.
  - multu: unsigned 64-bit product.
  - msub: {HI,LO} = {HI,LO} − signed(A)·signed(B), modulo 2^64.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div/divu with B=0: `pend_valid=0`. busy still runs DIV_CYCLES, and HI/LO are left unchanged.
  - div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- Commit: on the edge where `cnt` goes 1→0, HI/LO ← `res_hi`/`res_lo` if `pend_valid`.
- mthi/mtlo (op 6/5, start=0):
  - Write A into HI or LO at the edge, only when busy=0.
  - Ignored while busy; the stall logic prevents this.
- mfhi/mflo: `md_out` is combinational. During busy it returns the pre-operation HI/LO.
- Reset (any time, including mid-operation): HI=LO=0, cnt=0, busy=0, `pend_valid=0`, `res_*`=0. The in-flight result is discarded.

## Timing
- Launch accepted at edge t0. busy is high for cycles t0+1 … t0+N, where N = MULT_CYCLES or DIV_CYCLES.
- At edge t0+N:
  - HI/LO take the new value.
  - busy falls.
  - The new HI/LO is visible in the same cycle busy reads 0.
- Back-to-back: a start presented in the first cycle with busy=0 after completion is accepted and sees the committed HI/LO (msub chaining).
- mthi/mtlo latency: 1 edge. An mfhi in the next cycle sees the written value.
- The controller-side stall condition for HI/LO users is `start | busy`. md_unit itself never stalls.
- Output values after reset: busy=0, HI=0, LO=0; `md_out` follows op.

## Structure
- Shared package `md_pkg`:
  - op-code constants MD_NONE…MD_MSUB (0–9)
  - default latency constants (5, 10)
- Single module. No sub-module; 64-bit product and division are inferred operators inside one sequential block plus a small combinational read mux.
- `cnt` width is $clog2(DIV_CYCLES+1); a width of 4 covers the defaults.

## Test plan
- mult A=0xFFFFFFFE (−2), B=3, start at t0 → busy high t0+1..t0+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- divu A=7, B=2, followed by div A=−7 (0xFFFFFFF9), B=2 → first gives LO=3, HI=1 after 10 busy cycles; second gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi 0, mtlo 10, then msub A=2, B=3 → after 5 cycles HI=0, LO=4. Repeat msub A=1, B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- div B=0 with HI=0x11, LO=0x22 → busy for 10 cycles; HI/LO stay 0x11/0x22.
- start mult while busy, and mthi while busy → both ignored; the original result commits on schedule and HI is unchanged by the mthi.
- reset asserted mid-way through a div (cycle 4 of 10) → busy=0, HI=LO=0 immediately; no late commit after reset is released.

Source files
------------

// File: rtl/md_pkg.sv
// Shared op-code encoding and default latencies for the multiply/divide unit.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTLO  = 4'd5,
    MD_MTHI  = 4'd6,
    MD_MFLO  = 4'd7,
    MD_MFHI  = 4'd8,
    MD_MSUB  = 4'd9
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO; the result is
// computed at launch and committed when the busy counter expires.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  alupro_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q, res_hi_q, res_lo_q;
  logic          pend_valid_q;

  md_op_e        op;
  logic          launch_d, sext_d, is_div_d, div_zero_d, pend_valid_d;
  logic [63:0]   a64_d, b64_d, prod_d, res_d;
  logic [32:0]   a33_d, b33_d;
  logic [31:0]   quo_d, rem_d;
  logic [CW-1:0] lat_d;

  assign busy = (cnt_q != '0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    op           = md_op_e'(alupro_op);
    is_div_d     = (op == MD_DIV) || (op == MD_DIVU);
    launch_d     = start && !busy &&
                   (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MSUB});
    sext_d       = (op == MD_MULT) || (op == MD_DIV) || (op == MD_MSUB);
    a64_d        = {{32{sext_d & A[31]}}, A};
    b64_d        = {{32{sext_d & B[31]}}, B};
    prod_d       = a64_d * b64_d;
    // 33-bit signed division keeps 0x80000000 / -1 representable; zero divisor
    // is replaced by 1 only to keep the operator defined, the result is dropped.
    div_zero_d   = (B == '0);
    a33_d        = {sext_d & A[31], A};
    b33_d        = div_zero_d ? 33'd1 : {sext_d & B[31], B};
    quo_d        = 32'($signed(a33_d) / $signed(b33_d));
    rem_d        = 32'($signed(a33_d) % $signed(b33_d));
    pend_valid_d = !(is_div_d && div_zero_d);
    lat_d        = is_div_d ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    unique case (op)
      MD_MULT, MD_MULTU: res_d = prod_d;
      MD_MSUB:           res_d = {hi_q, lo_q} - prod_d;
      MD_DIV, MD_DIVU:   res_d = {rem_d, quo_d};
      default:           res_d = '0;
    endcase
  end

  always_comb begin
    unique case (op)
      MD_MFHI: md_out = hi_q;
      MD_MFLO: md_out = lo_q;
      default: md_out = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      res_hi_q     <= '0;
      res_lo_q     <= '0;
      pend_valid_q <= 1'b0;
    end else if (busy) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1) && pend_valid_q) begin
        hi_q <= res_hi_q;
        lo_q <= res_lo_q;
      end
    end else if (launch_d) begin
      cnt_q        <= lat_d;
      res_hi_q     <= res_d[63:32];
      res_lo_q     <= res_d[31:0];
      pend_valid_q <= pend_valid_d;
    end else begin
      if (op == MD_MTHI) hi_q <= A;
      if (op == MD_MTLO) lo_q <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: launches push expected HI/LO and busy length,
// a monitor pops and compares whenever busy falls.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alupro_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, md_out;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .alupro_op(alupro_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .md_out(md_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] mhi = '0, mlo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: 64-bit longint arithmetic straight from the op definitions.
  function automatic exp_t ref_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l);
    exp_t   e;
    longint sa, sb, ua, ub, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.lat = (op == 3 || op == 4) ? 10 : 5;
    r = {h, l};
    case (op)
      1: r = sa * sb;
      2: r = ua * ub;
      9: r = {h, l} - sa * sb;
      3: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
      4: if (b != 0) r = {32'(ua % ub), 32'(ua / ub)};
      default: ;
    endcase
    e.hi = r[63:32];
    e.lo = r[31:0];
    return e;
  endfunction

  // Monitor: counts busy cycles and checks the commit when busy falls.
  int   bcnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) bcnt++;
      else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_commit: busy fell with empty scoreboard");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("commit_hi", HI, e.hi);
          check("commit_lo", LO, e.lo);
          check("busy_len", 32'(bcnt), 32'(e.lat));
        end
        bcnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic launch(input int op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    e = ref_op(op, a, b, mhi, mlo);
    sb_q.push_back(e);
    mhi = e.hi;
    mlo = e.lo;
    start = 1'b1; alupro_op = 4'(op); A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; alupro_op = 4'd0;
  endtask

  task automatic mt(input int op, input logic [31:0] a);
    wait_idle();
    alupro_op = 4'(op); A = a;
    @(posedge clk); #1;
    alupro_op = 4'd0;
    if (op == 6) mhi = a; else mlo = a;
  endtask

  task automatic chk_md(input string tag);
    wait_idle();
    alupro_op = 4'd8; #1; check({tag, "_mfhi"}, md_out, mhi);
    alupro_op = 4'd7; #1; check({tag, "_mflo"}, md_out, mlo);
    alupro_op = 4'd0; #1; check({tag, "_mdnone"}, md_out, 32'h0);
  endtask

  initial begin
    logic [31:0] ph, pl;
    int ops[7] = '{1, 2, 3, 4, 9, 5, 6};
    reset = 1'b1; start = 1'b0; alupro_op = 4'd0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    reset = 1'b0;

    launch(1, 32'hFFFFFFFE, 32'd3);
    chk_md("mult");
    launch(4, 32'd7, 32'd2);
    launch(3, 32'hFFFFFFF9, 32'd2);
    chk_md("div");

    mt(6, 32'd0);
    mt(5, 32'd10);
    chk_md("mtx");
    launch(9, 32'd2, 32'd3);
    launch(9, 32'd1, 32'd5);
    chk_md("msub");

    mt(6, 32'h11);
    mt(5, 32'h22);
    launch(3, 32'h1234, 32'd0);
    chk_md("divzero");
    launch(3, 32'h80000000, 32'hFFFFFFFF);
    chk_md("divovf");

    // Start and mthi while busy must both be ignored.
    ph = mhi; pl = mlo;
    launch(2, 32'hDEADBEEF, 32'h12345678);
    @(negedge clk);
    start = 1'b1; alupro_op = 4'd1; A = 32'h7; B = 32'h9;
    @(posedge clk); #1;
    start = 1'b0; alupro_op = 4'd6; A = 32'hCAFEF00D;
    @(posedge clk); #1;
    alupro_op = 4'd8; #1; check("busy_mfhi_old", md_out, ph);
    alupro_op = 4'd7; #1; check("busy_mflo_old", md_out, pl);
    alupro_op = 4'd0;
    chk_md("ignored");

    for (int i = 0; i < 40; i++) begin
      int op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 6)];
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      if (op == 5 || op == 6) mt(op, a);
      else launch(op, a, b);
    end
    chk_md("rand");

    // Reset in the middle of a div discards the pending result.
    launch(3, 32'd1000, 32'd7);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    sb_q.delete();
    mhi = '0; mlo = '0;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_hi", HI, 32'h0);
    check("midrst_lo", LO, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("postrst_busy", 32'(busy), 32'h0);
    check("postrst_hi", HI, 32'h0);
    check("postrst_lo", LO, 32'h0);

    launch(1, 32'd6, 32'd7);
    wait_idle();
    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
